// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : IF/DM arbiter and sequencer for the shared 32-bit memory port.
//            Define MEMARB_STARVE_GUARD_EN to enable the IF starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        sel,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

    state_t      r_state;
    logic        r_sel;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_idle;
    logic        w_force_if;
    logic        w_gnt_i;
    logic        w_gnt_d;
    logic        w_done;

`ifdef MEMARB_STARVE_GUARD_EN
    logic [3:0] r_starve_cnt;

    assign w_force_if = (r_starve_cnt == c_limit);

    // Counts DM wins that left IF waiting; saturates so IF wins at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_gnt_i) begin
            r_starve_cnt <= 4'd0;
        end else if (w_gnt_d && if_req && (r_starve_cnt != c_limit)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`else
    // Strict DM priority; the limit can never be reached.
    assign w_force_if = (c_limit == 4'd0);
`endif

    assign w_idle = (r_state == S_IDLE);

    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (rst_n && w_idle) begin
            if (dm_req && !(if_req && w_force_if)) begin
                w_gnt_d = 1'b1;
            end else if (if_req) begin
                w_gnt_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_d) begin
                        r_state <= S_BUSY_D;
                        r_sel   <= 1'b1;
                        r_we    <= dm_we;
                        r_be    <= dm_be;
                        r_addr  <= dm_addr;
                        r_wdata <= dm_wdata;
                    end else if (w_gnt_i) begin
                        r_state <= S_BUSY_I;
                        r_sel   <= 1'b0;
                        r_we    <= 1'b0;
                        r_be    <= 4'hF;
                        r_addr  <= if_addr;
                        r_wdata <= 32'd0;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (mem_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A transaction being aborted by reset must not complete.
    assign w_done    = rst_n && mem_ready && !w_idle;

    assign if_gnt    = w_gnt_i;
    assign dm_gnt    = w_gnt_d;
    assign if_rvalid = w_done && (r_state == S_BUSY_I);
    assign dm_rvalid = w_done && (r_state == S_BUSY_D);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : 32'd0;

    assign mem_req   = !w_idle;
    assign busy      = !w_idle;
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign sel       = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter (directed + random traffic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;
`ifdef MEMARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic [3:0]  dm_be = '0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic        mem_req, mem_we, sel, busy;
    logic [3:0]  mem_be;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .sel(sel), .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        if_q[$];
    txn_t        dm_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] drv_rdata = '0;
    bit          auto_en = 1'b0;
    int          if_rate = 0, dm_rate = 0, ready_rate = 0;
    bit          if_gnt_seen = 1'b0, dm_gnt_seen = 1'b0;
    bit          rec_en = 1'b0;
    string       gseq = "";

    // Reference model: which requester owns the port and the IF wait count.
    int          m_owner = 0;   // 0 none, 1 IF, 2 DM
    int          m_cnt = 0;
    logic        m_sel = 1'b0;
    txn_t        cur = '{1'b0, 4'd0, 32'd0, 32'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic eg_i, eg_d, done, ev_i, ev_d;
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (rst_n && m_owner == 0) begin
            if (dm_req && if_req) begin
                if (GUARD && m_cnt == LIMIT) eg_i = 1'b1;
                else                         eg_d = 1'b1;
            end else if (dm_req) eg_d = 1'b1;
            else if (if_req)     eg_i = 1'b1;
        end
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, eg_i});
        chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, eg_d});
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_owner != 0});
        chk("busy", {31'd0, busy}, {31'd0, m_owner != 0});
        chk("sel", {31'd0, sel}, {31'd0, m_sel});

        done = 1'b0;
        if (m_owner != 0) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
            chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_wdata", mem_wdata, cur.wdata);
            done = rst_n && mem_ready;
        end
        ev_i = done && (m_owner == 1);
        ev_d = done && (m_owner == 2);
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, ev_i});
        chk("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, ev_d});
        chk("if_rdata", if_rdata, ev_i ? drv_rdata : 32'd0);
        if (!ev_d)        chk("dm_rdata_idle", dm_rdata, 32'd0);
        else if (!cur.we) chk("dm_rdata", dm_rdata, drv_rdata);

        if (rec_en && rst_n) begin
            if (dm_gnt)      gseq = {gseq, "D"};
            else if (if_gnt) gseq = {gseq, "I"};
        end

        if (!rst_n) begin
            m_owner = 0;
            m_cnt   = 0;
            m_sel   = 1'b0;
        end else if (m_owner != 0) begin
            if (mem_ready) m_owner = 0;
        end else if (eg_i || eg_d) begin
            if (eg_i) begin
                m_owner = 1;
                m_sel   = 1'b0;
                m_cnt   = 0;
                if (if_q.size() == 0) chk("if_queue_empty", 32'd0, 32'd1);
                else cur = if_q.pop_front();
            end else begin
                m_owner = 2;
                m_sel   = 1'b1;
                if (if_req && m_cnt < LIMIT) m_cnt++;
                if (dm_q.size() == 0) chk("dm_queue_empty", 32'd0, 32'd1);
                else cur = dm_q.pop_front();
            end
        end
        if_gnt_seen = if_gnt;
        dm_gnt_seen = dm_gnt;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_en) begin
            if (if_req && if_gnt_seen) if_req = 1'b0;
            if (!if_req && $urandom_range(0, 99) < if_rate) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
                if_q.push_back('{1'b0, 4'hF, if_addr, 32'd0});
            end
            if (dm_req && dm_gnt_seen) dm_req = 1'b0;
            if (!dm_req && $urandom_range(0, 99) < dm_rate) begin
                dm_req   = 1'b1;
                dm_we    = $urandom_range(0, 1) == 1;
                dm_be    = 4'($urandom);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
                dm_q.push_back('{dm_we, dm_be, dm_addr, dm_wdata});
            end
            mem_ready = ($urandom_range(0, 99) < ready_rate);
            drv_rdata = $urandom;
            mem_rdata = drv_rdata;
        end
    endtask

    task automatic drain();
        auto_en    = 1'b1;
        if_rate    = 0;
        dm_rate    = 0;
        ready_rate = 50;
        for (int i = 0; i < 300 && (if_req || dm_req || busy); i++) step();
        chk("drain_done", {31'd0, if_req || dm_req || busy}, 32'd0);
        auto_en   = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        string exp_seq;
        // Reset with both requesters pending, then continuous contention.
        auto_en    = 1'b1;
        if_rate    = 100;
        dm_rate    = 100;
        ready_rate = 100;
        step();
        step();
        chk("rst_ctrl", {26'd0, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, busy}, 32'd0);
        chk("rst_port", {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        chk("rst_sel", {31'd0, sel}, 32'd0);
        rst_n  = 1'b1;
        gseq   = "";
        rec_en = 1'b1;
        #1;
        chk("first_grant_dm", {30'd0, if_gnt, dm_gnt}, 32'd1);
        for (int i = 0; i < 22; i++) step();
        rec_en  = 1'b0;
        exp_seq = GUARD ? "DDDDIDDDDI" : "DDDDDDDDDD";
        tests++;
        if (gseq.len() < 10 || gseq.substr(0, 9) != exp_seq) begin
            fails++;
            $display("FAIL grant_sequence: got %s expected %s...", gseq, exp_seq);
        end
        drain();

        // IF read, ready on cycle 3
        step();
        if_req  = 1'b1;
        if_addr = 32'h100;
        if_q.push_back('{1'b0, 4'hF, 32'h100, 32'd0});
        #1 chk("ifrd_gnt", {31'd0, if_gnt}, 32'd1);
        step();
        if_req = 1'b0;
        #1 chk("ifrd_c1", {31'd0, mem_req}, 32'd1);
        chk("ifrd_addr_c1", mem_addr, 32'h100);
        step();
        #1 chk("ifrd_c2", {31'd0, mem_req}, 32'd1);
        step();
        mem_ready = 1'b1;
        drv_rdata = 32'hDEAD_BEEF;
        mem_rdata = drv_rdata;
        #1 chk("ifrd_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("ifrd_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("ifrd_addr_c3", mem_addr, 32'h100);
        step();
        mem_ready = 1'b0;
        #1 chk("ifrd_idle", {30'd0, mem_req, busy}, 32'd0);

        // DM write
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_be    = 4'b0011;
        dm_addr  = 32'h2004;
        dm_wdata = 32'h1234;
        dm_q.push_back('{1'b1, 4'b0011, 32'h2004, 32'h1234});
        #1 chk("dmwr_gnt", {31'd0, dm_gnt}, 32'd1);
        step();
        dm_req = 1'b0;
        #1 chk("dmwr_port", {26'd0, sel, mem_we, mem_be}, {26'd0, 1'b1, 1'b1, 4'b0011});
        chk("dmwr_addr", mem_addr, 32'h2004);
        chk("dmwr_wdata", mem_wdata, 32'h1234);
        step();
        mem_ready = 1'b1;
        drv_rdata = 32'h0BAD_F00D;
        mem_rdata = drv_rdata;
        #1 chk("dmwr_valid", {30'd0, dm_rvalid, if_rvalid}, 32'd2);
        step();
        mem_ready = 1'b0;

        // Stray ready while idle
        step();
        mem_ready = 1'b1;
        #1 chk("stray_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        step();
        #1 chk("stray_state", {30'd0, mem_req, busy}, 32'd0);
        mem_ready = 1'b0;

        // Reset while BUSY_D
        step();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_be   = 4'hF;
        dm_addr = 32'h40;
        dm_q.push_back('{1'b0, 4'hF, 32'h40, dm_wdata});
        step();
        dm_req = 1'b0;
        step();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1 chk("rstbusy_rvalid", {31'd0, dm_rvalid}, 32'd0);
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1 chk("rstbusy_idle", {29'd0, mem_req, busy, dm_rvalid}, 32'd0);
        chk("rstbusy_sel", {31'd0, sel}, 32'd0);

        // Random traffic
        auto_en    = 1'b1;
        if_rate    = 40;
        dm_rate    = 40;
        ready_rate = 50;
        for (int i = 0; i < 3000; i++) step();
        drain();
        step();
        step();
        chk("if_q_empty", if_q.size(), 32'd0);
        chk("dm_q_empty", dm_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, failed %0d", fails);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
